key_hit_capture: RTL and testbench

Front-end for the F1–F4 lane buttons: synchronises and debounces the four raw key inputs, turns each clean press into a single event, and holds that event until the next refresh tick. It sits directly upstream of the falling-block manager and drives its `f_key_hit[3:0]` input. The manager therefore sees each press exactly once, held stable for one full refresh period, and aligned to its row-shift step.

---
 rtl/rhythm_pkg.sv | 31 +++
 rtl/key_debounce.sv | 62 ++++++
 rtl/key_hit_capture.sv | 79 +++++++
 tb/tb_key_hit_capture.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rhythm_pkg.sv
// ----------------------------------------------------------------------------
// rhythm_pkg
//   Shared constants for the rhythm-game front end.
//   - N_LANES / LANE_F1..LANE_F4 : lane count and the bit index of each button.
//   - CLK_HZ / DEBOUNCE_MS        : system clock and debounce window; their
//                                   product gives the default debounce length.
//   - GAME_RUN / GAME_PAUSE       : encoding of the game_state input.
// ----------------------------------------------------------------------------
package rhythm_pkg;

    localparam int N_LANES     = 4;
    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 10;

    localparam int LANE_F1 = 0;
    localparam int LANE_F2 = 1;
    localparam int LANE_F3 = 2;
    localparam int LANE_F4 = 3;

    localparam logic GAME_RUN   = 1'b0;
    localparam logic GAME_PAUSE = 1'b1;

    // Clock cycles spanned by a window of 'ms' milliseconds.
    function automatic int debounce_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    // 500000 cycles = 10 ms at 50 MHz.
    localparam int DEBOUNCE_CYCLES_DEF = debounce_cycles(CLK_HZ, DEBOUNCE_MS);

endpackage

// File: rtl/key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
//   One button lane: 2-flop synchroniser followed by a stable-count debouncer.
//   A level change is accepted only after the synchronised input has
//   disagreed with the current level for DEBOUNCE_CYCLES consecutive cycles.
//
//   Ports
//     clk      in  : system clock
//     rst      in  : synchronous, active-high reset
//     key_raw  in  : asynchronous raw button, 1 = pressed
//     level    out : debounced level (registered)
//     press    out : one-cycle strobe on the cycle whose edge raises 'level'
// ----------------------------------------------------------------------------
module key_debounce
    import rhythm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_ff;
    logic             sync;
    logic [CNT_W-1:0] cnt;
    logic             terminal;

    // sync_ff[0] may go metastable; only sync_ff[1] is used downstream.
    assign sync = sync_ff[1];

    // Terminal cycle: input has disagreed long enough, level flips on this edge.
    assign terminal = (sync != level) && (cnt == CNT_LAST);

    // Only rising acceptances are events; releases are silent.
    assign press = terminal && sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
            level   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_ff <= {sync_ff[0], key_raw};
            if (sync == level) begin
                // Any agreement restarts the count, so short glitches vanish.
                cnt <= '0;
            end else if (terminal) begin
                level <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_hit_capture.sv
// ----------------------------------------------------------------------------
// key_hit_capture
//   Front end for the F1..F4 lane buttons. Each lane is debounced, every clean
//   press becomes a single event, events are collected between refresh ticks
//   and issued together on the tick, then held for one full refresh period.
//
//   Ports
//     clk           in  : system clock (only clock)
//     rst           in  : synchronous, active-high reset
//     key_raw       in  : [N_KEYS] raw asynchronous buttons, 1 = pressed
//     refresh_tick  in  : one-cycle refresh step strobe (clk domain)
//     game_state    in  : GAME_RUN / GAME_PAUSE
//     f_key_hit     out : [N_KEYS] hits issued at the last tick, held a period
//     key_level     out : [N_KEYS] debounced levels for the LED/debug display
//     hit_pending   out : [N_KEYS] presses captured since the last tick
// ----------------------------------------------------------------------------
module key_hit_capture
    import rhythm_pkg::*;
#(
    parameter int N_KEYS          = N_LANES,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic              refresh_tick,
    input  logic              game_state,
    output logic [N_KEYS-1:0] f_key_hit,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] hit_pending
);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
            $error("key_hit_capture: DEBOUNCE_CYCLES must be >= 2");
        end
    endgenerate

    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] pending;
    logic              paused;

    assign paused = (game_state == GAME_PAUSE);

    genvar k;
    generate
        for (k = 0; k < N_KEYS; k++) begin : g_lane
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .rst     (rst),
                .key_raw (key_raw[k]),
                .level   (key_level[k]),
                .press   (press[k])
            );
        end
    endgenerate

    // Pending/issue latch. A press landing on the tick cycle is folded into
    // the window being closed, so pending restarts empty after every tick.
    // Pause acts immediately: nothing is collected and a tick issues zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            f_key_hit <= '0;
        end else if (refresh_tick) begin
            f_key_hit <= paused ? '0 : (pending | press);
            pending   <= '0;
        end else if (paused) begin
            pending   <= '0;
        end else begin
            pending   <= pending | press;
        end
    end

    assign hit_pending = pending;

endmodule

// File: tb/tb_key_hit_capture.sv
// ----------------------------------------------------------------------------
// tb_key_hit_capture
//   Directed bench, DEBOUNCE_CYCLES = 4, refresh_tick on every 20th edge.
//   Edge numbering: the reset edge is edge 0; a key driven "after edge N"
//   is first sampled on edge N+1 and reaches key_level on edge N+6.
// ----------------------------------------------------------------------------
module tb_key_hit_capture;
    import rhythm_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] key_raw;
    logic       refresh_tick;
    logic       game_state;
    logic [3:0] f_key_hit;
    logic [3:0] key_level;
    logic [3:0] hit_pending;

    int t;
    int checks;
    int errors;

    key_hit_capture #(
        .N_KEYS          (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_raw      (key_raw),
        .refresh_tick (refresh_tick),
        .game_state   (game_state),
        .f_key_hit    (f_key_hit),
        .key_level    (key_level),
        .hit_pending  (hit_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge; outputs are then read 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
        t++;
        refresh_tick = ((t + 1) % 20 == 0);
    endtask

    task automatic step_to(input int n);
        while (t < n) step();
    endtask

    // Hold reset for n edges; the last reset edge becomes edge 0.
    task automatic do_reset(input int n);
        rst          = 1'b1;
        refresh_tick = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        t   = 0;
    endtask

    task automatic test_reset();
        key_raw    = 4'b0000;
        game_state = GAME_RUN;
        do_reset(2);
        checks++;
        if (f_key_hit !== 4'b0000) begin
            errors++;
            $display("FAIL reset_f_key_hit: got %b expected %b", f_key_hit, 4'b0000);
        end
        checks++;
        if (key_level !== 4'b0000) begin
            errors++;
            $display("FAIL reset_key_level: got %b expected %b", key_level, 4'b0000);
        end
        checks++;
        if (hit_pending !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hit_pending: got %b expected %b", hit_pending, 4'b0000);
        end
    endtask

    task automatic test_clean_press();
        key_raw = 4'b0000;
        do_reset(1);
        step_to(5);
        key_raw[LANE_F1] = 1'b1;
        step_to(10);
        checks++;
        if (key_level !== 4'b0000) begin
            errors++;
            $display("FAIL clean_level_early: got %b expected %b", key_level, 4'b0000);
        end
        step_to(11);
        checks++;
        if (key_level !== 4'b0001) begin
            errors++;
            $display("FAIL clean_level_rise: got %b expected %b", key_level, 4'b0001);
        end
        checks++;
        if (hit_pending !== 4'b0001) begin
            errors++;
            $display("FAIL clean_pending: got %b expected %b", hit_pending, 4'b0001);
        end
        step_to(19);
        checks++;
        if (f_key_hit !== 4'b0000) begin
            errors++;
            $display("FAIL clean_hit_before_tick: got %b expected %b", f_key_hit, 4'b0000);
        end
        step_to(20);
        checks++;
        if (f_key_hit !== 4'b0001 || hit_pending !== 4'b0000) begin
            errors++;
            $display("FAIL clean_tick: got hit %b pend %b expected hit 0001 pend 0000",
                     f_key_hit, hit_pending);
        end
        step_to(25);
        key_raw[LANE_F1] = 1'b0;
        step_to(31);
        checks++;
        if (key_level !== 4'b0000 || hit_pending !== 4'b0000) begin
            errors++;
            $display("FAIL clean_release: got level %b pend %b expected 0000 0000",
                     key_level, hit_pending);
        end
        step_to(39);
        checks++;
        if (f_key_hit !== 4'b0001) begin
            errors++;
            $display("FAIL clean_hold: got %b expected %b", f_key_hit, 4'b0001);
        end
        step_to(40);
        checks++;
        if (f_key_hit !== 4'b0000) begin
            errors++;
            $display("FAIL clean_clear: got %b expected %b", f_key_hit, 4'b0000);
        end
    endtask

    // 3 high / 2 low on F2: one cycle short of acceptance every time.
    task automatic test_glitch();
        key_raw = 4'b0000;
        do_reset(1);
        for (int c = 0; c < 45; c++) begin
            key_raw[LANE_F2] = ((c % 5) < 3);
            step();
            checks++;
            if ({key_level, hit_pending, f_key_hit} !== 12'h000) begin
                errors++;
                $display("FAIL glitch_edge_%0d: got level %b pend %b hit %b expected all 0",
                         t, key_level, hit_pending, f_key_hit);
            end
        end
        key_raw = 4'b0000;
    endtask

    task automatic test_merge();
        key_raw = 4'b0000;
        do_reset(1);
        // F3 pressed twice in window 1.
        step_to(1);  key_raw[LANE_F3] = 1'b1;
        step_to(7);  key_raw[LANE_F3] = 1'b0;
        step_to(13);
        checks++;
        if (key_level !== 4'b0000 || hit_pending !== 4'b0100) begin
            errors++;
            $display("FAIL merge_first: got level %b pend %b expected 0000 0100",
                     key_level, hit_pending);
        end
        key_raw[LANE_F3] = 1'b1;
        step_to(19);
        key_raw[LANE_F3] = 1'b0;
        checks++;
        if (hit_pending !== 4'b0100) begin
            errors++;
            $display("FAIL merge_second: got %b expected %b", hit_pending, 4'b0100);
        end
        step_to(20);
        checks++;
        if (f_key_hit !== 4'b0100) begin
            errors++;
            $display("FAIL merge_tick: got %b expected %b", f_key_hit, 4'b0100);
        end
        // F2 + F4 together in window 2.
        step_to(25); key_raw = 4'b1010;
        step_to(31); key_raw = 4'b0000;
        checks++;
        if (hit_pending !== 4'b1010) begin
            errors++;
            $display("FAIL multi_pending: got %b expected %b", hit_pending, 4'b1010);
        end
        step_to(40);
        checks++;
        if (f_key_hit !== 4'b1010) begin
            errors++;
            $display("FAIL multi_tick: got %b expected %b", f_key_hit, 4'b1010);
        end
        // F1 level rises exactly on the tick edge 60.
        step_to(54); key_raw[LANE_F1] = 1'b1;
        step_to(59);
        checks++;
        if (hit_pending !== 4'b0000 || key_level !== 4'b0000) begin
            errors++;
            $display("FAIL tickpress_pre: got pend %b level %b expected 0000 0000",
                     hit_pending, key_level);
        end
        step_to(60);
        checks++;
        if (f_key_hit !== 4'b0001 || hit_pending !== 4'b0000) begin
            errors++;
            $display("FAIL tickpress_tick: got hit %b pend %b expected 0001 0000",
                     f_key_hit, hit_pending);
        end
        key_raw = 4'b0000;
    endtask

    task automatic test_back_to_back();
        key_raw = 4'b0000;
        do_reset(1);
        step_to(3);  key_raw[LANE_F2] = 1'b1;
        step_to(20);
        checks++;
        if (f_key_hit !== 4'b0010) begin
            errors++;
            $display("FAIL b2b_first: got %b expected %b", f_key_hit, 4'b0010);
        end
        refresh_tick = 1'b1;
        step_to(21);
        checks++;
        if (f_key_hit !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_second: got %b expected %b", f_key_hit, 4'b0000);
        end
        key_raw = 4'b0000;
    endtask

    task automatic test_pause();
        key_raw    = 4'b0000;
        game_state = GAME_RUN;
        do_reset(1);
        game_state = GAME_PAUSE;
        step_to(3);  key_raw[LANE_F1] = 1'b1;
        step_to(9);
        checks++;
        if (key_level !== 4'b0001 || hit_pending !== 4'b0000) begin
            errors++;
            $display("FAIL pause_press: got level %b pend %b expected 0001 0000",
                     key_level, hit_pending);
        end
        step_to(12); key_raw[LANE_F1] = 1'b0;
        step_to(20);
        checks++;
        if (f_key_hit !== 4'b0000) begin
            errors++;
            $display("FAIL pause_tick: got %b expected %b", f_key_hit, 4'b0000);
        end
        game_state = GAME_RUN;
        step_to(22); key_raw[LANE_F1] = 1'b1;
        step_to(28);
        checks++;
        if (hit_pending !== 4'b0001) begin
            errors++;
            $display("FAIL resume_pending: got %b expected %b", hit_pending, 4'b0001);
        end
        step_to(30); key_raw[LANE_F1] = 1'b0;
        step_to(40);
        checks++;
        if (f_key_hit !== 4'b0001) begin
            errors++;
            $display("FAIL resume_tick: got %b expected %b", f_key_hit, 4'b0001);
        end
        // Pending F2 is dropped the moment pause is sampled.
        step_to(42); key_raw[LANE_F2] = 1'b1;
        step_to(48);
        checks++;
        if (hit_pending !== 4'b0010) begin
            errors++;
            $display("FAIL prepause_pending: got %b expected %b", hit_pending, 4'b0010);
        end
        step_to(50);
        key_raw    = 4'b0000;
        game_state = GAME_PAUSE;
        step_to(51);
        checks++;
        if (hit_pending !== 4'b0000) begin
            errors++;
            $display("FAIL pause_clears_pending: got %b expected %b", hit_pending, 4'b0000);
        end
        step_to(60);
        checks++;
        if (f_key_hit !== 4'b0000) begin
            errors++;
            $display("FAIL pause_tick2: got %b expected %b", f_key_hit, 4'b0000);
        end
        game_state = GAME_RUN;
    endtask

    task automatic test_reset_mid();
        key_raw    = 4'b0000;
        game_state = GAME_RUN;
        do_reset(1);
        step_to(3);  key_raw[LANE_F4] = 1'b1;
        step_to(10); key_raw[LANE_F4] = 1'b0;
        step_to(33); key_raw = 4'b0011;
        step_to(39);
        checks++;
        if (hit_pending !== 4'b0011 || f_key_hit !== 4'b1000) begin
            errors++;
            $display("FAIL rstmid_pre: got pend %b hit %b expected 0011 1000",
                     hit_pending, f_key_hit);
        end
        // Reset coincides with a tick and keys stay held through it.
        rst = 1'b1;
        step_to(40);
        rst = 1'b0;
        checks++;
        if ({key_level, hit_pending, f_key_hit} !== 12'h000) begin
            errors++;
            $display("FAIL rstmid_clear: got level %b pend %b hit %b expected all 0",
                     key_level, hit_pending, f_key_hit);
        end
        step_to(45);
        checks++;
        if (key_level !== 4'b0000) begin
            errors++;
            $display("FAIL rsthold_early: got %b expected %b", key_level, 4'b0000);
        end
        step_to(46);
        checks++;
        if (key_level !== 4'b0011 || hit_pending !== 4'b0011) begin
            errors++;
            $display("FAIL rsthold_rise: got level %b pend %b expected 0011 0011",
                     key_level, hit_pending);
        end
        step_to(60);
        checks++;
        if (f_key_hit !== 4'b0011) begin
            errors++;
            $display("FAIL rsthold_tick: got %b expected %b", f_key_hit, 4'b0011);
        end
        key_raw = 4'b0000;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        t            = 0;
        rst          = 1'b1;
        key_raw      = 4'b0000;
        refresh_tick = 1'b0;
        game_state   = GAME_RUN;
        test_reset();
        test_clean_press();
        test_glitch();
        test_merge();
        test_back_to_back();
        test_pause();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
